ajust_ascii_muldiv: RTL and testbench

AJUST_ASCII_MULDIV -- requirements
Module: ajust_ascii_muldiv

---
 rtl/ajust_ascii_muldiv.sv | 178 +++++++++++++++++
 tb/tb_ajust_ascii_muldiv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ajust_ascii_muldiv.sv
// ajust_ascii_muldiv: iterative ASCII adjust after multiply (AAM) / before divide (AAD).
// AAM runs an 8-step restoring division of AL by the radix; AAD runs an 8-step
// shift-add of AH*radix and then adds AL. Both give a 9-cycle latency, and a new
// request may be issued back-to-back during the done cycle.
// Optional feature macro: AJUST_IMM_BASE_EN adds the 'base' port, which supplies
// the radix. AAM with a radix of zero reports a divide error after one cycle.
module ajust_ascii_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] Ain,
`ifdef AJUST_IMM_BASE_EN
    input  logic [7:0]  base,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] A,
    output logic        SF,
    output logic        ZF,
    output logic        PF,
    output logic        DE
);

    typedef enum logic [1:0] {IDLE, AAM_DIV, AAD_MAC, FIN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  iter_q, iter_d;
    logic [7:0]  work_q, work_d;
    logic [7:0]  al_q, al_d;
    logic [7:0]  acc_q, acc_d;
    logic [15:0] a_q, a_d;
    logic        sf_q, sf_d, zf_q, zf_d, pf_q, pf_d;
    logic [7:0]  radix;
    logic [8:0]  rem_sh;
    logic [7:0]  mac;
    logic [7:0]  res_lo;
    logic        upd_flags;
    logic        de_d;

`ifdef AJUST_IMM_BASE_EN
    logic [7:0]  radix_q, radix_d;
    logic        de_q;
    assign radix = radix_q;
    assign DE    = de_q;
`else
    assign radix = 8'd10;
    assign DE    = 1'b0;
`endif

    assign busy = (state_q == AAM_DIV) || (state_q == AAD_MAC);
    assign done = (state_q == FIN);
    assign A    = a_q;
    assign SF   = sf_q;
    assign ZF   = zf_q;
    assign PF   = pf_q;

    // Next-state logic: capture operands on accept, iterate, and commit the result on the last step
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        work_d    = work_q;
        al_d      = al_q;
        acc_d     = acc_q;
        a_d       = a_q;
        sf_d      = sf_q;
        zf_d      = zf_q;
        pf_d      = pf_q;
        rem_sh    = 9'd0;
        mac       = 8'd0;
        res_lo    = 8'd0;
        upd_flags = 1'b0;
        de_d      = 1'b0;
`ifdef AJUST_IMM_BASE_EN
        radix_d   = radix_q;
        de_d      = de_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    work_d  = op ? Ain[15:8] : Ain[7:0];
                    al_d    = Ain[7:0];
                    acc_d   = 8'd0;
                    iter_d  = 3'd0;
                    state_d = op ? AAD_MAC : AAM_DIV;
`ifdef AJUST_IMM_BASE_EN
                    radix_d = base;
                    if (!op && (base == 8'd0)) begin
                        state_d = FIN;
                        a_d     = Ain;
                        de_d    = 1'b1;
                    end
`endif
                end
            end
            AAM_DIV: begin
                rem_sh = {acc_q, work_q[7]};
                iter_d = iter_q + 3'd1;
                if (rem_sh >= {1'b0, radix}) begin
                    acc_d  = rem_sh[7:0] - radix;
                    work_d = {work_q[6:0], 1'b1};
                end else begin
                    acc_d  = rem_sh[7:0];
                    work_d = {work_q[6:0], 1'b0};
                end
                if (iter_q == 3'd7) begin
                    state_d   = FIN;
                    a_d       = {work_d, acc_d};
                    res_lo    = acc_d;
                    upd_flags = 1'b1;
                    de_d      = 1'b0;
                end
            end
            AAD_MAC: begin
                mac    = {acc_q[6:0], 1'b0} + (work_q[7] ? radix : 8'd0);
                acc_d  = mac;
                work_d = {work_q[6:0], 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d   = FIN;
                    res_lo    = mac + al_q;
                    a_d       = {8'h00, res_lo};
                    upd_flags = 1'b1;
                    de_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (upd_flags) begin
            sf_d = res_lo[7];
            zf_d = (res_lo == 8'd0);
            pf_d = ~^res_lo;
        end
    end

    // State and datapath registers with synchronous reset clearing every output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= 3'd0;
            work_q  <= 8'd0;
            al_q    <= 8'd0;
            acc_q   <= 8'd0;
            a_q     <= 16'd0;
            sf_q    <= 1'b0;
            zf_q    <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            work_q  <= work_d;
            al_q    <= al_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            sf_q    <= sf_d;
            zf_q    <= zf_d;
            pf_q    <= pf_d;
        end
    end

`ifdef AJUST_IMM_BASE_EN
    // Captured radix and divide-error flag for the selectable-base build
    always_ff @(posedge clk) begin
        if (rst) begin
            radix_q <= 8'd0;
            de_q    <= 1'b0;
        end else begin
            radix_q <= radix_d;
            de_q    <= de_d;
        end
    end
`else
    logic unused_de;
    assign unused_de = de_d;
`endif

endmodule

// File: tb/tb_ajust_ascii_muldiv.sv
// tb_ajust_ascii_muldiv: directed bench with an expected-result queue for ajust_ascii_muldiv.
// Define AJUST_IMM_BASE_EN for both files to exercise the selectable-base build.
module tb_ajust_ascii_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] Ain;
`ifdef AJUST_IMM_BASE_EN
    logic [7:0]  base;
`endif
    logic        busy, done, SF, ZF, PF, DE;
    logic [15:0] A;

    typedef struct {
        logic [15:0] a;
        logic        sf, zf, pf, de;
        int          doneCyc;
    } exp_t;

    exp_t sb[$];
    exp_t lastExp;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    ajust_ascii_muldiv dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .Ain   (Ain),
`ifdef AJUST_IMM_BASE_EN
        .base  (base),
`endif
        .busy  (busy),
        .done  (done),
        .A     (A),
        .SF    (SF),
        .ZF    (ZF),
        .PF    (PF),
        .DE    (DE)
    );

    // Free-running clock and edge counter used to time done pulses
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [15:0] ain, input logic [7:0] r);
        exp_t e;
        int   t;
        logic [7:0] lo;
        if (!o) begin
            e.a = {8'(int'(ain[7:0]) / int'(r)), 8'(int'(ain[7:0]) % int'(r))};
        end else begin
            t   = (int'(ain[15:8]) * int'(r) + int'(ain[7:0])) % 256;
            e.a = {8'h00, 8'(t)};
        end
        lo   = e.a[7:0];
        e.sf = lo[7];
        e.zf = (lo == 8'd0);
        e.pf = ~^lo;
        e.de = 1'b0;
        e.doneCyc = 0;
        return e;
    endfunction

    // Drives one start pulse (caller ensures the block is idle or in its done cycle)
    task automatic applyStimulus(input logic o, input logic [15:0] ain, input logic [7:0] r, input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        Ain   = ain;
`ifdef AJUST_IMM_BASE_EN
        base  = r;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        Ain   = 16'($urandom);
`ifdef AJUST_IMM_BASE_EN
        base  = 8'($urandom);
`endif
        if (push) begin
            if (!o && r == 8'd0) begin
                e    = lastExp;
                e.a  = ain;
                e.de = 1'b1;
                e.doneCyc = cyc;
            end else begin
                e = model(o, ain, r);
                e.doneCyc = cyc + 8;
            end
            lastExp = e;
            sb.push_back(e);
        end
    endtask

    // Waits (bounded) for done, then compares against the oldest queued expectation
    task automatic checkOutput(input string tag);
        exp_t e;
        bit   seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen || sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
            return;
        end
        e = sb.pop_front();
        checkValue({tag, "_cycle"}, 32'(cyc), 32'(e.doneCyc));
        checkValue({tag, "_A"},     32'(A),   32'(e.a));
        checkValue({tag, "_SF"},    32'(SF),  32'(e.sf));
        checkValue({tag, "_ZF"},    32'(ZF),  32'(e.zf));
        checkValue({tag, "_PF"},    32'(PF),  32'(e.pf));
        checkValue({tag, "_DE"},    32'(DE),  32'(e.de));
        checkValue({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    // Directed sequence covering reset, both operations, ignored starts, abort and back-to-back
    initial begin
        int  firstDone;
        bit  sawDone;
        rst   = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        Ain   = 16'h0041;
`ifdef AJUST_IMM_BASE_EN
        base  = 8'd10;
`endif
        lastExp = '{a: 16'h0, sf: 1'b0, zf: 1'b0, pf: 1'b0, de: 1'b0, doneCyc: 0};
        repeat (3) @(posedge clk);
        #1;
        checkValue("rst_busy", 32'(busy), 32'd0);
        checkValue("rst_done", 32'(done), 32'd0);
        checkValue("rst_A",    32'(A),    32'd0);
        checkValue("rst_flags", 32'({SF, ZF, PF, DE}), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 16'h0041, 8'd10, 1'b1);
        checkOutput("aam_0041");
        applyStimulus(1'b1, 16'h0705, 8'd10, 1'b1);
        checkOutput("aad_0705");
        applyStimulus(1'b1, 16'h1909, 8'd10, 1'b1);
        checkOutput("aad_1909_wrap");

        repeat (3) @(negedge clk);
        checkValue("hold_A",  32'(A),  32'h0003);
        checkValue("hold_PF", 32'(PF), 32'd1);

        applyStimulus(1'b0, 16'h1200, 8'd10, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 1'b1;
        Ain   = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkValue("ignored_busy", 32'(busy), 32'd1);
        checkOutput("aam_1200_ignore");

        applyStimulus(1'b0, 16'h0063, 8'd10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkValue("abort_busy", 32'(busy), 32'd0);
        checkValue("abort_A",    32'(A),    32'd0);
        checkValue("abort_flags", 32'({done, SF, ZF, PF, DE}), 32'd0);
        rst = 1'b0;
        lastExp = '{a: 16'h0, sf: 1'b0, zf: 1'b0, pf: 1'b0, de: 1'b0, doneCyc: 0};
        sawDone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) sawDone = 1;
        end
        checkValue("abort_no_done", 32'(sawDone), 32'd0);

        applyStimulus(1'b1, 16'h0102, 8'd10, 1'b1);
        checkOutput("aad_0102_after_rst");
        firstDone = cyc;
        applyStimulus(1'b1, 16'h0300, 8'd10, 1'b1);
        checkOutput("aad_0300_b2b");
        checkValue("b2b_spacing", 32'(cyc - firstDone), 32'd9);

`ifdef AJUST_IMM_BASE_EN
        applyStimulus(1'b0, 16'h00FF, 8'd16, 1'b1);
        checkOutput("aam_base16");
        applyStimulus(1'b0, 16'h00FF, 8'd0, 1'b1);
        checkOutput("aam_base0_de");
        applyStimulus(1'b1, 16'h0203, 8'd7, 1'b1);
        checkOutput("aad_base7");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
